dmem_arbiter: RTL and testbench

- Access controller in front of the single-ported, byte-addressed, big-endian data memory of the five-stage pipeline.
- Shares the memory between two requesters:
  - port A: pipeline MEM stage.
  - port B: loader/debug master.
- Issues only aligned 32-bit memory operations. Byte and halfword stores become read-modify-write sequences; byte and halfword loads are extracted from the word.
- Stalls the pipeline while port A's access is outstanding.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported, word-wide, big-endian data memory.
// Sub-word stores become read-modify-write sequences; sub-word loads are lane-extracted.
module dmem_arbiter #(
  parameter int MEM_BYTES = 32,
  parameter int AW = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [1:0]    a_size,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  output logic          a_ack,
  output logic          a_err,
  output logic          a_stall,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [1:0]    b_size,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR} state_t;

  state_t      state;
  logic        gnt;        // 0 = port A owns the current transaction, 1 = port B
  logic        last_gnt;
  logic        wr_r;
  logic [1:0]  size_r;
  logic [1:0]  offset_r;
  logic [15:0] wdata_r;
  logic        ack_r;
  logic        err_r;

  logic          pick_b;
  logic          sel_wr;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_bad;

  // Both requesting: take the port that was not granted last.
  always_comb begin
    pick_b    = b_req & (~a_req | ~last_gnt);
    sel_wr    = pick_b ? b_wr    : a_wr;
    sel_size  = pick_b ? b_size  : a_size;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
    sel_bad   = (sel_size == 2'b11)
              | ((sel_size == 2'b01) & sel_addr[0])
              | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
              | (sel_addr >= AW'(MEM_BYTES));
  end

  logic [7:0]  rd_lane    [4];
  logic [7:0]  wr_lane    [4];
  logic [7:0]  merge_lane [4];
  logic [3:0]  lane_en;
  logic [31:0] merge_word;
  logic [31:0] load_data;

  always_comb begin
    lane_en = 4'b0000;
    if (size_r == 2'b00)
      lane_en = 4'b0001 << offset_r;
    else if (size_r == 2'b01)
      lane_en = offset_r[1] ? 4'b1100 : 4'b0011;
  end

  // Lane gi is byte offset gi, i.e. bits [31-8*gi -: 8] of the big-endian word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi]    = mem_rdata[31-8*gi -: 8];
    assign wr_lane[gi]    = (size_r == 2'b01 && (gi % 2) == 0) ? wdata_r[15:8] : wdata_r[7:0];
    assign merge_lane[gi] = lane_en[gi] ? wr_lane[gi] : rd_lane[gi];
  end

  assign merge_word = {merge_lane[0], merge_lane[1], merge_lane[2], merge_lane[3]};

  always_comb begin
    load_data = mem_rdata;
    if (size_r == 2'b00)
      load_data = {24'd0, rd_lane[offset_r]};
    else if (size_r == 2'b01)
      load_data = {16'd0, rd_lane[{offset_r[1], 1'b0}], rd_lane[{offset_r[1], 1'b1}]};
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      wr_r      <= 1'b0;
      size_r    <= 2'b00;
      offset_r  <= 2'b00;
      wdata_r   <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack_r  <= 1'b0;
      err_r  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            gnt      <= pick_b;
            last_gnt <= pick_b;
            wr_r     <= sel_wr;
            size_r   <= sel_size;
            offset_r <= sel_addr[1:0];
            wdata_r  <= sel_wdata[15:0];
            if (sel_bad) begin
              state <= ERR;
              ack_r <= 1'b1;
              err_r <= 1'b1;
            end else if (sel_wr && sel_size == 2'b10) begin
              state     <= WR;
              mem_addr  <= {sel_addr[AW-1:2], 2'b00};
              mem_wdata <= sel_wdata;
              mem_we    <= 1'b1;
              ack_r     <= 1'b1;
            end else begin
              state    <= RD;
              mem_addr <= {sel_addr[AW-1:2], 2'b00};
            end
          end
        end
        RD: begin
          state <= CAP;
          // Loads complete in CAP, when the read word arrives.
          if (!wr_r)
            ack_r <= 1'b1;
        end
        CAP: begin
          if (wr_r) begin
            state     <= WR;
            mem_wdata <= merge_word;
            mem_we    <= 1'b1;
            ack_r     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WR:      state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign a_ack   = ack_r & ~gnt;
  assign b_ack   = ack_r & gnt;
  assign a_err   = err_r & ~gnt;
  assign b_err   = err_r & gnt;
  assign a_rdata = (a_ack && state == CAP) ? load_data : 32'd0;
  assign b_rdata = (b_ack && state == CAP) ? load_data : 32'd0;
  assign a_stall = a_req & ~a_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: byte-level shadow memory predicts every ack,
// a synchronous-read word memory model sits on the memory port.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        a_req = 1'b0, a_wr = 1'b0;
  logic [1:0]  a_size = 2'b00;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic [31:0] a_rdata;
  logic        a_ack, a_err, a_stall;
  logic        b_req = 1'b0, b_wr = 1'b0;
  logic [1:0]  b_size = 2'b00;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic [31:0] b_rdata;
  logic        b_ack, b_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.MEM_BYTES(32), .AW(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .a_req(a_req), .a_wr(a_wr), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err), .a_stall(a_stall),
    .b_req(b_req), .b_wr(b_wr), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:7];
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr[4:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[4:2]];
  end

  typedef struct { logic err; logic [31:0] rdata; } exp_t;
  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] shadow [0:31];
  int         checks = 0;
  int         failures = 0;
  int         cycle = 0;
  int         we_count = 0;
  bit         ack_order[$];
  int         ack_cycle[$];

  function automatic void push_expect(input bit port, input bit wr, input logic [1:0] size,
                                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int n;
    logic [31:0] d;
    e.err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd32);
    e.rdata = 32'd0;
    if (!e.err) begin
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      d = 32'd0;
      for (int i = 0; i < n; i++) begin
        if (wr) shadow[int'(addr) + i] = wdata[8*(n-1-i) +: 8];
        else    d = {d[23:0], shadow[int'(addr) + i]};
      end
      if (!wr) e.rdata = d;
    end
    if (port) exp_b.push_back(e);
    else      exp_a.push_back(e);
  endfunction

  // Scoreboard: every ack pops the oldest expectation of its port.
  always @(negedge CLK) begin
    exp_t e;
    cycle++;
    if (mem_we) we_count++;
    if (a_ack && b_ack) begin
      checks++; failures++;
      $display("FAIL dual_ack: a_ack=%b b_ack=%b, required at most one", a_ack, b_ack);
    end
    if (a_ack) begin
      ack_order.push_back(1'b0); ack_cycle.push_back(cycle);
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_ack: ack with err=%b rdata=%h, required no ack", a_err, a_rdata);
      end else begin
        e = exp_a.pop_front();
        if ({a_err, a_rdata} !== {e.err, e.rdata}) begin
          failures++;
          $display("FAIL a_result: err=%b rdata=%h, required err=%b rdata=%h", a_err, a_rdata, e.err, e.rdata);
        end
      end
    end
    if (b_ack) begin
      ack_order.push_back(1'b1); ack_cycle.push_back(cycle);
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_ack: ack with err=%b rdata=%h, required no ack", b_err, b_rdata);
      end else begin
        e = exp_b.pop_front();
        if ({b_err, b_rdata} !== {e.err, e.rdata}) begin
          failures++;
          $display("FAIL b_result: err=%b rdata=%h, required err=%b rdata=%h", b_err, b_rdata, e.err, e.rdata);
        end
      end
    end
  end

  // Called just after a rising edge; returns cycles from the sampling edge to ack.
  task automatic do_txn(input bit port, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int we_lat,
                        output logic [31:0] we_data, output int stall_bad);
    bit ack, stall;
    push_expect(port, wr, size, addr, wdata);
    if (port) begin b_req = 1; b_wr = wr; b_size = size; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1; a_wr = wr; a_size = size; a_addr = addr; a_wdata = wdata; end
    lat = 0; we_lat = 0; we_data = 32'd0; stall_bad = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (mem_we && we_lat == 0) begin we_lat = lat; we_data = mem_wdata; end
      ack = port ? b_ack : a_ack;
      stall = port ? !b_ack : a_stall;
      if (stall !== !ack) stall_bad++;
    end while (!ack && lat < 40);
    $display("txn port=%s wr=%0d size=%0d addr=%h wdata=%h lat=%0d", port ? "B" : "A", wr, size, addr, wdata, lat);
    @(posedge CLK); #1;
    if (port) b_req = 0; else a_req = 0;
  endtask

  task automatic test_reset;
    Reset = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({a_ack, b_ack, a_err, b_err, mem_we} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: ack/err/we=%b, required 00000", {a_ack, b_ack, a_err, b_err, mem_we});
    end
    checks++;
    if ({a_rdata, b_rdata} !== 64'd0) begin
      failures++;
      $display("FAIL reset_rdata: a=%h b=%h, required 0", a_rdata, b_rdata);
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      failures++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    checks++;
    if (a_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: a_stall=%b, required 0", a_stall);
    end
    @(posedge CLK); #1;
    Reset = 1;
    @(posedge CLK); #1;
  endtask

  task automatic test_word_store_load;
    int lat, wl, sb; logic [31:0] wd;
    do_txn(0, 1, 2'b10, 32'h08, 32'h11223344, lat, wl, wd, sb);
    checks++;
    if (lat !== 1 || wl !== 1 || wd !== 32'h11223344 || sb !== 0) begin
      failures++;
      $display("FAIL word_store: lat=%0d we_lat=%0d wdata=%h stall_bad=%0d, required 1 1 11223344 0", lat, wl, wd, sb);
    end
    do_txn(0, 0, 2'b10, 32'h08, 32'h0, lat, wl, wd, sb);
    checks++;
    if (lat !== 2 || wl !== 0 || sb !== 0) begin
      failures++;
      $display("FAIL word_load: lat=%0d we_lat=%0d stall_bad=%0d, required 2 0 0", lat, wl, sb);
    end
  endtask

  task automatic test_byte_rmw;
    int lat, wl, sb; logic [31:0] wd;
    do_txn(0, 1, 2'b10, 32'h04, 32'hAABBCCDD, lat, wl, wd, sb);
    do_txn(0, 1, 2'b00, 32'h06, 32'h0000005A, lat, wl, wd, sb);
    checks++;
    if (lat !== 3 || wl !== 3 || wd !== 32'hAABB5ADD || sb !== 0) begin
      failures++;
      $display("FAIL byte_rmw: lat=%0d we_lat=%0d wdata=%h stall_bad=%0d, required 3 3 aabb5add 0", lat, wl, wd, sb);
    end
    for (int k = 4; k < 8; k++)
      do_txn(0, 0, 2'b00, 32'(k), 32'h0, lat, wl, wd, sb);
    do_txn(0, 0, 2'b01, 32'h04, 32'h0, lat, wl, wd, sb);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL half_load_latency: lat=%0d, required 2", lat);
    end
    do_txn(0, 1, 2'b01, 32'h10, 32'h0000BEEF, lat, wl, wd, sb);
    checks++;
    if (lat !== 3 || wd !== 32'hBEEF0000) begin
      failures++;
      $display("FAIL half_rmw: lat=%0d wdata=%h, required 3 beef0000", lat, wd);
    end
    do_txn(0, 0, 2'b01, 32'h06, 32'h0, lat, wl, wd, sb);
  endtask

  task automatic test_errors;
    int lat, wl, sb, we0; logic [31:0] wd;
    logic [1:0]  sz [5] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b11};
    logic [31:0] ad [5] = '{32'h03, 32'h0A, 32'h20, 32'h20, 32'h00};
    bit          wr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    we0 = we_count;
    for (int i = 0; i < 5; i++) begin
      do_txn(i == 4, wr[i], sz[i], ad[i], 32'hDEADBEEF, lat, wl, wd, sb);
      checks++;
      if (lat !== 1 || wl !== 0) begin
        failures++;
        $display("FAIL error_latency[%0d]: lat=%0d we_lat=%0d, required 1 0", i, lat, wl);
      end
    end
    checks++;
    if (we_count !== we0) begin
      failures++;
      $display("FAIL error_no_write: we cycles=%0d, required %0d", we_count, we0);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int lat, wl, sb, we0; logic [31:0] wd;
    we0 = we_count;
    a_req = 1; a_wr = 1; a_size = 2'b00; a_addr = 32'h05; a_wdata = 32'h77;
    @(posedge CLK);
    @(posedge CLK); #1;
    Reset = 0;
    @(posedge CLK); #1;
    Reset = 1; a_req = 0;
    @(negedge CLK);
    checks++;
    if ({a_ack, a_err, mem_we, a_rdata, mem_addr, mem_wdata} !== 99'd0) begin
      failures++;
      $display("FAIL mid_rmw_reset_outputs: ack=%b err=%b we=%b rdata=%h addr=%h wdata=%h, required all 0",
               a_ack, a_err, mem_we, a_rdata, mem_addr, mem_wdata);
    end
    @(posedge CLK); @(negedge CLK);
    checks++;
    if (we_count !== we0 || mem[1] !== 32'hAABB5ADD) begin
      failures++;
      $display("FAIL mid_rmw_no_write: we cycles=%0d word=%h, required %0d aabb5add", we_count, mem[1], we0);
    end
    @(posedge CLK); #1;
    do_txn(0, 1, 2'b00, 32'h05, 32'h77, lat, wl, wd, sb);
    checks++;
    if (lat !== 3 || wd !== 32'hAA775ADD) begin
      failures++;
      $display("FAIL mid_rmw_reissue: lat=%0d wdata=%h, required 3 aa775add", lat, wd);
    end
  endtask

  task automatic test_back_to_back;
    int lat, wl, sb; logic [31:0] wd;
    do_txn(1, 1, 2'b10, 32'h0C, 32'hCAFEF00D, lat, wl, wd, sb);
    do_txn(1, 0, 2'b10, 32'h0C, 32'h0, lat, wl, wd, sb);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL b2b_first_load: lat=%0d, required 2", lat);
    end
    do_txn(1, 0, 2'b00, 32'h0D, 32'h0, lat, wl, wd, sb);
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL b2b_second_load: lat=%0d, required 2", lat);
    end
  endtask

  task automatic test_contention;
    Reset = 0;
    @(posedge CLK); #1;
    Reset = 1;
    ack_order.delete(); ack_cycle.delete();
    fork
      begin
        int l, w, s; logic [31:0] d;
        do_txn(0, 0, 2'b10, 32'h08, 32'h0, l, w, d, s);
        do_txn(0, 0, 2'b10, 32'h10, 32'h0, l, w, d, s);
      end
      begin
        int l, w, s; logic [31:0] d;
        do_txn(1, 0, 2'b10, 32'h0C, 32'h0, l, w, d, s);
        do_txn(1, 0, 2'b10, 32'h04, 32'h0, l, w, d, s);
      end
    join
    checks++;
    if (ack_order.size() !== 4) begin
      failures++;
      $display("FAIL rr_count: acks=%0d, required 4", ack_order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_order[i] !== bit'(i % 2)) begin
          failures++;
          $display("FAIL rr_order[%0d]: port=%0d, required %0d", i, ack_order[i], i % 2);
        end
        if (i > 0) begin
          checks++;
          if (ack_cycle[i] - ack_cycle[i-1] !== 3) begin
            failures++;
            $display("FAIL rr_gap[%0d]: %0d cycles, required 3", i, ack_cycle[i] - ack_cycle[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_final;
    repeat (2) @(posedge CLK);
    checks++;
    if (exp_a.size() !== 0 || exp_b.size() !== 0) begin
      failures++;
      $display("FAIL pending_acks: a=%0d b=%0d outstanding, required 0 0", exp_a.size(), exp_b.size());
    end
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (mem[w] !== {shadow[4*w], shadow[4*w+1], shadow[4*w+2], shadow[4*w+3]}) begin
        failures++;
        $display("FAIL mem_word[%0d]: %h, required %h", w, mem[w],
                 {shadow[4*w], shadow[4*w+1], shadow[4*w+2], shadow[4*w+3]});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) shadow[i] = 8'd0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_contention();
    test_final();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
